// File: rtl/vec_seq_ctrl_pkg.sv
// Shared definitions for the vector sequence controller: FSM state encoding,
// vector geometry and the default stall timeout.
package vec_seq_ctrl_pkg;

    localparam int unsigned VEC_LEN            = 8;
    localparam int unsigned IDX_W              = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vec_seq_ctrl_iter_counter.sv
// iter_counter: element index counter for one vector operation.
// Ports:
//   clk      - clock, rising edge
//   i_clr    - synchronous clear (priority over enable)
//   i_en     - count enable, one step per accepted operand
//   o_count  - current element index
//   o_last   - combinational flag, index is the final element
module iter_counter
    import vec_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_count,
    output logic             o_last
);

    logic [IDX_W-1:0] r_count;

    // Natural wrap from VEC_LEN-1 back to 0 since VEC_LEN == 2**IDX_W.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + IDX_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == IDX_W'(VEC_LEN - 1));

endmodule

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: sequences one 8-element vector operation through the shared
// accumulate datapath (clear, 8 operand handshakes, result load, done pulse).
// Optional feature macro: VEC_SEQ_CTRL_TIMEOUT_EN (stall timeout abort).
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - begin operation, sampled only in IDLE
//   in_valid  - operand available from source
//   in_ready  - operand accepted this cycle (RUN)
//   clr_acc   - clear datapath accumulator (INIT)
//   acc_en    - accumulate current operand (handshake, combinational)
//   res_ld    - load result register (FLUSH)
//   idx       - element index used by the current handshake
//   busy      - high in every state except IDLE
//   done      - one-cycle completion pulse
//   err       - one-cycle timeout-abort pulse
module vec_seq_ctrl
    import vec_seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             clr_acc,
    output logic             acc_en,
    output logic             res_ld,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("vec_seq_ctrl: TIMEOUT_CYCLES must be nonzero");
    end

    state_t r_state;
    logic   r_in_ready;
    logic   r_clr_acc;
    logic   r_res_ld;
    logic   r_busy;
    logic   r_done;
    logic   r_err;

    logic   w_hs;
    logic   w_last;
    logic   w_abort;
    logic   w_cnt_clr;

    // r_in_ready is high exactly in RUN, so it doubles as the RUN qualifier.
    assign w_hs = in_valid & r_in_ready;

`ifdef VEC_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned STALL_W = cnt_width(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] r_stall;

    // Consecutive stalled RUN cycles; cleared by a handshake or outside RUN.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_RUN) || w_hs) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    // This stalled cycle is the TIMEOUT_CYCLES-th in a row.
    assign w_abort = (r_state == S_RUN) && !in_valid &&
                     (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_abort = 1'b0;
`endif

    assign w_cnt_clr = rst || (r_state == S_INIT) || w_abort;

    iter_counter u_iter_counter (
        .clk     (clk),
        .i_clr   (w_cnt_clr),
        .i_en    (w_hs),
        .o_count (idx),
        .o_last  (w_last)
    );

    // Controller FSM; Moore outputs are registered alongside the state they
    // belong to so they line up with the state cycle-for-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_clr_acc  <= 1'b0;
            r_res_ld   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_clr_acc <= 1'b0;
            r_res_ld  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_INIT;
                        r_busy    <= 1'b1;
                        r_clr_acc <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_state    <= S_RUN;
                    r_in_ready <= 1'b1;
                end
                S_RUN: begin
                    if (w_hs && w_last) begin
                        r_state    <= S_FLUSH;
                        r_in_ready <= 1'b0;
                        r_res_ld   <= 1'b1;
                    end else if (w_abort) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign clr_acc  = r_clr_acc;
    assign acc_en   = w_hs;
    assign res_ld   = r_res_ld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Self-checking bench for vec_seq_ctrl: a cycle-level reference model pushes
// expected outputs into a scoreboard queue as each cycle's stimulus is driven;
// outputs are popped and compared at the falling edge. Directed timing checks
// on top of that pin down the absolute cycle numbers from the timing diagram.
module tb_vec_seq_ctrl;

    localparam int unsigned TO = 16;

    typedef struct packed {
        logic       busy;
        logic       in_ready;
        logic       clr_acc;
        logic       acc_en;
        logic       res_ld;
        logic       done;
        logic       err;
        logic [2:0] idx;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       clr_acc;
    logic       acc_en;
    logic       res_ld;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    obs_t sb_q[$];

    // Reference model state: 0 IDLE, 1 INIT, 2 RUN, 3 FLUSH, 4 DONE.
    int m_st    = 0;
    int m_idx   = 0;
    int m_stall = 0;
    bit m_err   = 1'b0;

    always #5 clk = ~clk;

    vec_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clr_acc  (clr_acc),
        .acc_en   (acc_en),
        .res_ld   (res_ld),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic obs_t model_out(input logic v);
        obs_t e;
        e.busy     = (m_st != 0);
        e.in_ready = (m_st == 2);
        e.clr_acc  = (m_st == 1);
        e.acc_en   = v && (m_st == 2);
        e.res_ld   = (m_st == 3);
        e.done     = (m_st == 4);
        e.err      = m_err;
        e.idx      = 3'(m_idx);
        return e;
    endfunction

    task automatic model_step(input logic s, input logic v, input logic r);
        m_err = 1'b0;
        if (r) begin
            m_st = 0; m_idx = 0; m_stall = 0;
        end else begin
            case (m_st)
                0: if (s) m_st = 1;
                1: begin m_idx = 0; m_st = 2; end
                2: begin
                    if (v) begin
                        m_stall = 0;
                        if (m_idx == 7) begin m_idx = 0; m_st = 3; end
                        else m_idx = m_idx + 1;
                    end else begin
                        m_stall = m_stall + 1;
`ifdef VEC_SEQ_CTRL_TIMEOUT_EN
                        if (m_stall == TO) begin
                            m_err = 1'b1; m_st = 0; m_idx = 0; m_stall = 0;
                        end
`endif
                    end
                end
                3: m_st = 4;
                default: m_st = 0;
            endcase
            if (m_st != 2) m_stall = 0;
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare at negedge.
    task automatic cyc(input logic s, input logic v, input logic r, output obs_t o);
        obs_t e;
        start = s; in_valid = v; rst = r;
        sb_q.push_back(model_out(v));
        model_step(s, v, r);
        @(negedge clk);
        o = '{busy, in_ready, clr_acc, acc_en, res_ld, done, err, idx};
        e = sb_q.pop_front();
        chk("cycle", 32'(o), 32'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        obs_t o;
        int clr_c, res_c, done_c, err_c, acc_n, busy_n, done_n, bad_idx;
        int clr2_c, done2_c;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        phase = "reset";
        cyc(1'b0, 1'b1, 1'b1, o);
        chk("reset_outputs", 32'(o), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, o);

        // Back-to-back operands.
        phase = "b2b";
        clr_c = -1; res_c = -1; done_c = -1; acc_n = 0; busy_n = 0; bad_idx = 0;
        for (int t = 0; t <= 12; t++) begin
            cyc(t == 0, 1'b1, 1'b0, o);
            if (o.clr_acc) clr_c = t;
            if (o.res_ld)  res_c = t;
            if (o.done)    done_c = t;
            if (o.busy)    busy_n++;
            if (o.acc_en) begin
                acc_n++;
                if (int'(o.idx) != t - 2) bad_idx++;
            end
            if ((t == 0 || t == 12) && o.busy) bad_idx++;
        end
        chk("clr_cycle", 32'(clr_c), 32'd1);
        chk("res_ld_cycle", 32'(res_c), 32'd10);
        chk("done_cycle", 32'(done_c), 32'd11);
        chk("acc_count", 32'(acc_n), 32'd8);
        chk("busy_cycles", 32'(busy_n), 32'd11);
        chk("acc_idx_order", 32'(bad_idx), 32'd0);

        // Three stall cycles while idx sits at 4.
        phase = "stall3";
        done_c = -1; acc_n = 0; bad_idx = 0;
        for (int t = 0; t <= 15; t++) begin
            cyc(t == 0, !(t >= 6 && t <= 8), 1'b0, o);
            if (o.done) done_c = t;
            if (o.acc_en) acc_n++;
            if (t >= 6 && t <= 9 && (o.idx != 3'd4)) bad_idx++;
            if (t >= 6 && t <= 8 && o.acc_en) bad_idx++;
        end
        chk("done_cycle", 32'(done_c), 32'd14);
        chk("acc_count", 32'(acc_n), 32'd8);
        chk("idx_hold", 32'(bad_idx), 32'd0);

        // start held high: one op completes, next INIT in cycle 13.
        phase = "start_held";
        clr_c = -1; clr2_c = -1; done_c = -1; done2_c = -1; done_n = 0;
        for (int t = 0; t <= 25; t++) begin
            cyc(t <= 13, 1'b1, 1'b0, o);
            if (o.clr_acc) begin if (clr_c < 0) clr_c = t; else clr2_c = t; end
            if (o.done) begin
                if (done_c < 0) done_c = t; else done2_c = t;
                if (t <= 12) done_n++;
            end
        end
        chk("first_init", 32'(clr_c), 32'd1);
        chk("second_init", 32'(clr2_c), 32'd13);
        chk("done_once", 32'(done_n), 32'd1);
        chk("first_done", 32'(done_c), 32'd11);
        chk("second_done", 32'(done2_c), 32'd23);

        // Reset mid-RUN at idx 5, then a clean full run.
        phase = "rst_mid";
        bad_idx = 0;
        for (int t = 0; t <= 9; t++) begin
            cyc(t == 0, 1'b1, t == 7, o);
            if (t == 7) chk("idx_at_rst", 32'(o.idx), 32'd5);
            if (t == 8) chk("after_rst", 32'(o), 32'd0);
            if (o.done || o.res_ld || o.err) bad_idx++;
        end
        chk("no_done_after_abort", 32'(bad_idx), 32'd0);
        done_c = -1; acc_n = 0; bad_idx = 0;
        for (int t = 0; t <= 12; t++) begin
            cyc(t == 0, 1'b1, 1'b0, o);
            if (o.done) done_c = t;
            if (o.acc_en) begin
                acc_n++;
                if (int'(o.idx) != t - 2) bad_idx++;
            end
        end
        chk("rerun_done", 32'(done_c), 32'd11);
        chk("rerun_acc", 32'(acc_n), 32'd8);
        chk("rerun_idx", 32'(bad_idx), 32'd0);

        // in_valid dropped after the idx 2 handshake.
        phase = "timeout";
        err_c = -1; bad_idx = 0;
`ifdef VEC_SEQ_CTRL_TIMEOUT_EN
        for (int t = 0; t <= 24; t++) begin
            cyc(t == 0, t <= 4, 1'b0, o);
            if (o.err) begin if (err_c < 0) err_c = t; else bad_idx++; end
            if (o.done || o.res_ld) bad_idx++;
            if (t == 22) chk("idle_after_err", 32'({o.busy, o.idx}), 32'd0);
        end
        chk("err_cycle", 32'(err_c), 32'd21);
        chk("no_flush", 32'(bad_idx), 32'd0);
`else
        for (int t = 0; t <= 40; t++) begin
            cyc(t == 0, t <= 4, 1'b0, o);
            if (o.err || o.done || o.res_ld) bad_idx++;
            if (t == 40) chk("still_run", 32'({o.busy, o.in_ready, o.idx}), 32'h1B);
        end
        chk("no_err", 32'(bad_idx), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, o);
        cyc(1'b0, 1'b0, 1'b0, o);
        chk("rst_exit", 32'(o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
